// File: rtl/uart_io_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_io_pkg
// Shared definitions for the register-mapped UART controller: register
// addresses, STATUS bit positions, FSM state encodings and bit timing.
// Optional feature macro: UART_PARITY_EN. When it is defined, a PARITY state
// is added to both the TX and the RX state enums.
// ---------------------------------------------------------------------------
package uart_io_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_TX_DROPPED = 4;
    localparam int ST_PARITY_ERR = 5;

    localparam int TICKS_PER_BIT = 16;
    localparam int HALF_BIT      = 8;

    // Terminal values of the 4-bit per-bit tick counters
    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] HALF_LAST = 4'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } txState_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rxState_e;

endpackage

// File: rtl/uart_io_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// uart_tick_gen
// Programmable oversampling tick generator. The counter runs 0..div and
// 'tick' pulses for one clock on the wrap cycle, so the period is div+1
// clocks (div = 0 ticks every clock).
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   div   - wrap value (BAUD_DIV register)
//   clr   - restarts the count from zero on this edge
//   tick  - one-clock oversampling pulse
// ---------------------------------------------------------------------------
module uart_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] div,
    input  logic        clr,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: wrap at div, or restart when the divider is rewritten.
    // Using >= keeps the counter sane when div is lowered below the count.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clr || (cnt_q >= div)) begin
            cnt_d = 16'd0;
        end
    end

    // The tick is suppressed on a clear edge so a new divider starts cleanly
    assign tick = !clr && (cnt_q >= div);

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// ---------------------------------------------------------------------------
// uart_io_ctrl
// Register-mapped UART controller for I/O device slot 1. Owns rx/tx pins.
// Registers: 0 DATA, 1 STATUS (W1C bits 1..5), 2 BAUD_DIV, 3 CTRL.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   cs, we       - device select and write strobe (write on cs&&we)
//   reg_sel      - register address
//   in / out     - write data / combinational read data
//   rx / tx      - serial input (asynchronous) / serial output (idle high)
// Optional feature macro: UART_PARITY_EN (even parity bit, STATUS bit5).
// ---------------------------------------------------------------------------
import uart_io_pkg::*;

module uart_io_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = 16'd325,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic [15:0] in,
    output logic [15:0] out,
    input  logic        rx,
    output logic        tx
);

    logic        wrData, wrStatus, wrBaud, wrCtrl;
    logic        tick;
    logic [15:0] baudDiv_q;
    logic        txEn_q, rxEn_q;
    logic [SYNC_STAGES-1:0] rxSync_q;
    logic        rxS, rxPrev_q;

    txState_e    txState_q;
    logic        tx_q, txBusy_q, txDropped_q;
    logic [7:0]  txData_q;
    logic [2:0]  txBit_q;
    logic [3:0]  txTick_q;

    rxState_e    rxState_q;
    logic [7:0]  rxShift_q, rxData_q;
    logic [2:0]  rxBit_q;
    logic [3:0]  rxTick_q;
    logic        rxValid_q, rxOverrun_q, frameErr_q, rxWaitHigh_q;
    logic        parityErr;

`ifdef UART_PARITY_EN
    logic        parityErr_q;
    assign parityErr = parityErr_q;
`else
    assign parityErr = 1'b0;
`endif

    assign wrData   = cs && we && (reg_sel == REG_DATA);
    assign wrStatus = cs && we && (reg_sel == REG_STATUS);
    assign wrBaud   = cs && we && (reg_sel == REG_BAUD);
    assign wrCtrl   = cs && we && (reg_sel == REG_CTRL);
    assign tx       = tx_q;
    assign rxS      = rxSync_q[SYNC_STAGES-1];

    uart_tick_gen u_tick (
        .clk   (clk),
        .reset (reset),
        .div   (baudDiv_q),
        .clr   (wrBaud),
        .tick  (tick)
    );

    // Configuration registers: divider and the two enables
    always_ff @(posedge clk) begin
        if (reset) begin
            baudDiv_q <= DEFAULT_DIV;
            txEn_q    <= 1'b1;
            rxEn_q    <= 1'b1;
        end else begin
            if (wrBaud) begin
                baudDiv_q <= in;
            end
            if (wrCtrl) begin
                txEn_q <= in[0];
                rxEn_q <= in[1];
            end
        end
    end

    // rx crosses into the clk domain through a shift-register synchronizer;
    // rxPrev_q holds the previous synchronized level for falling-edge detect.
    // Reset to all ones so an idle line does not look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxSync_q <= '1;
            rxPrev_q <= 1'b1;
        end else begin
            rxSync_q <= {rxSync_q[SYNC_STAGES-2:0], rx};
            rxPrev_q <= rxS;
        end
    end

    // Transmit FSM. Each bit is held for 16 ticks; the tick counter wraps
    // by itself so it only needs explicit clearing when a frame starts.
    // tx_dropped's W1C comes first so a same-cycle hardware set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            txState_q   <= TX_IDLE;
            tx_q        <= 1'b1;
            txBusy_q    <= 1'b0;
            txDropped_q <= 1'b0;
            txData_q    <= 8'h00;
            txBit_q     <= 3'd0;
            txTick_q    <= 4'd0;
        end else begin
            if (wrStatus && in[ST_TX_DROPPED]) begin
                txDropped_q <= 1'b0;
            end
            if (wrData && (txBusy_q || !txEn_q)) begin
                txDropped_q <= 1'b1;
            end
            case (txState_q)
                TX_IDLE: begin
                    if (wrData && txEn_q) begin
                        txData_q  <= in[7:0];
                        tx_q      <= 1'b0;
                        txBusy_q  <= 1'b1;
                        txTick_q  <= 4'd0;
                        txState_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        txTick_q <= txTick_q + 4'd1;
                        if (txTick_q == LAST_TICK) begin
                            txBit_q   <= 3'd0;
                            tx_q      <= txData_q[0];
                            txState_q <= TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        txTick_q <= txTick_q + 4'd1;
                        if (txTick_q == LAST_TICK) begin
                            if (txBit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                                tx_q      <= ^txData_q;
                                txState_q <= TX_PARITY;
`else
                                tx_q      <= 1'b1;
                                txState_q <= TX_STOP;
`endif
                            end else begin
                                txBit_q <= txBit_q + 3'd1;
                                tx_q    <= txData_q[txBit_q + 3'd1];
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tick) begin
                        txTick_q <= txTick_q + 4'd1;
                        if (txTick_q == LAST_TICK) begin
                            tx_q      <= 1'b1;
                            txState_q <= TX_STOP;
                        end
                    end
                end
`endif
                TX_STOP: begin
                    if (tick) begin
                        txTick_q <= txTick_q + 4'd1;
                        if (txTick_q == LAST_TICK) begin
                            txBusy_q  <= 1'b0;
                            txState_q <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    txState_q <= TX_IDLE;
                    tx_q      <= 1'b1;
                    txBusy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Receive FSM. Start is qualified at mid-bit (8 ticks) to reject
    // glitches, then every later sample lands mid-bit 16 ticks apart.
    // After a bad stop bit the FSM parks in STOP until the line is high
    // again so a held-low line cannot retrigger a start. W1C clears come
    // first so hardware sets later in the block take priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxState_q    <= RX_IDLE;
            rxShift_q    <= 8'h00;
            rxData_q     <= 8'h00;
            rxBit_q      <= 3'd0;
            rxTick_q     <= 4'd0;
            rxValid_q    <= 1'b0;
            rxOverrun_q  <= 1'b0;
            frameErr_q   <= 1'b0;
            rxWaitHigh_q <= 1'b0;
`ifdef UART_PARITY_EN
            parityErr_q  <= 1'b0;
`endif
        end else begin
            if (wrStatus) begin
                if (in[ST_RX_VALID])   rxValid_q   <= 1'b0;
                if (in[ST_RX_OVERRUN]) rxOverrun_q <= 1'b0;
                if (in[ST_FRAME_ERR])  frameErr_q  <= 1'b0;
`ifdef UART_PARITY_EN
                if (in[ST_PARITY_ERR]) parityErr_q <= 1'b0;
`endif
            end
            if (!rxEn_q) begin
                rxState_q    <= RX_IDLE;
                rxWaitHigh_q <= 1'b0;
            end else begin
                case (rxState_q)
                    RX_IDLE: begin
                        if (rxPrev_q && !rxS) begin
                            rxTick_q  <= 4'd0;
                            rxState_q <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (tick) begin
                            rxTick_q <= rxTick_q + 4'd1;
                            if (rxTick_q == HALF_LAST) begin
                                rxTick_q <= 4'd0;
                                rxBit_q  <= 3'd0;
                                rxState_q <= rxS ? RX_IDLE : RX_DATA;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (tick) begin
                            rxTick_q <= rxTick_q + 4'd1;
                            if (rxTick_q == LAST_TICK) begin
                                rxShift_q <= {rxS, rxShift_q[7:1]};
                                rxBit_q   <= rxBit_q + 3'd1;
                                if (rxBit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                                    rxState_q <= RX_PARITY;
`else
                                    rxState_q <= RX_STOP;
`endif
                                end
                            end
                        end
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: begin
                        if (tick) begin
                            rxTick_q <= rxTick_q + 4'd1;
                            if (rxTick_q == LAST_TICK) begin
                                if (rxS != ^rxShift_q) begin
                                    parityErr_q <= 1'b1;
                                end
                                rxState_q <= RX_STOP;
                            end
                        end
                    end
`endif
                    RX_STOP: begin
                        if (rxWaitHigh_q) begin
                            if (rxS) begin
                                rxWaitHigh_q <= 1'b0;
                                rxState_q    <= RX_IDLE;
                            end
                        end else if (tick) begin
                            rxTick_q <= rxTick_q + 4'd1;
                            if (rxTick_q == LAST_TICK) begin
                                if (rxS) begin
                                    rxData_q  <= rxShift_q;
                                    rxValid_q <= 1'b1;
                                    if (rxValid_q) begin
                                        rxOverrun_q <= 1'b1;
                                    end
                                    rxState_q <= RX_IDLE;
                                end else begin
                                    frameErr_q   <= 1'b1;
                                    rxWaitHigh_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        rxState_q <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    // Read mux: purely combinational, independent of cs, no side effects
    always_comb begin
        out = 16'h0000;
        case (reg_sel)
            REG_DATA:   out = {8'h00, rxData_q};
            REG_STATUS: out = {10'h000, parityErr, txDropped_q, frameErr_q,
                               rxOverrun_q, rxValid_q, txBusy_q};
            REG_BAUD:   out = baudDiv_q;
            REG_CTRL:   out = {14'h0000, rxEn_q, txEn_q};
            default:    out = 16'h0000;
        endcase
    end

endmodule
